// File: rtl/dir_input_queue.sv
// Button front end for the snake controller: sync, debounce, validate turns,
// and release one buffered turn per game tick.
module dir_input_queue #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         left,
  input  logic                         right,
  input  logic                         up,
  input  logic                         down,
  input  logic                         tick,
  output logic [1:0]                   dir,
  output logic [$clog2(QUEUE_DEPTH):0] q_count,
  output logic                         rejected,
  output logic                         dropped
);

  localparam logic [1:0] TOP_DIR   = 2'd0;
  localparam logic [1:0] DOWN_DIR  = 2'd1;
  localparam logic [1:0] LEFT_DIR  = 2'd2;
  localparam logic [1:0] RIGHT_DIR = 2'd3;

  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int QW   = PW + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] FULL = QW'(QUEUE_DEPTH);

  // Bit index of each button equals its direction code.
  logic [3:0] pins;
  assign pins = {right, left, down, up};

  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    deb;
  logic [3:0]    deb_q;
  logic [CW-1:0] cnt [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1    <= pins;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] rp;
  logic [PW-1:0] wp;

  logic [3:0] rise;
  logic       onehot;
  logic [1:0] pdir;
  logic [1:0] ref_dir;
  logic       pop;
  logic       push;
  logic       rej_n;
  logic       drop_n;

  assign rise    = deb & ~deb_q;
  assign onehot  = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
  assign ref_dir = (q_count != '0) ? mem[wp - 1'b1] : dir;
  assign pop     = tick && (q_count != '0);

  always_comb begin
    pdir = TOP_DIR;
    case (1'b1)
      rise[1]: pdir = DOWN_DIR;
      rise[2]: pdir = LEFT_DIR;
      rise[3]: pdir = RIGHT_DIR;
      default: pdir = TOP_DIR;
    endcase
  end

  // Opposite pairs differ only in bit 0 of the encoding.
  always_comb begin
    push   = 1'b0;
    rej_n  = 1'b0;
    drop_n = 1'b0;
    if (rise != 4'd0) begin
      if (!onehot || deb != rise || pdir == ref_dir
          || pdir == (ref_dir ^ 2'b01)) begin
        rej_n = 1'b1;
      end else if (q_count == FULL && !pop) begin
        drop_n = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir      <= TOP_DIR;
      q_count  <= '0;
      rp       <= '0;
      wp       <= '0;
      rejected <= 1'b0;
      dropped  <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
    end else begin
      rejected <= rej_n;
      dropped  <= drop_n;
      if (push) begin
        mem[wp] <= pdir;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        dir <= mem[rp];
        rp  <= rp + 1'b1;
      end
      if (push && !pop) q_count <= q_count + 1'b1;
      else if (pop && !push) q_count <= q_count - 1'b1;
    end
  end

endmodule
